ahb_spi_fifo_master: RTL



---
 rtl/ahb_spi_pkg.sv | 39 +++
 rtl/ahb_spi_fifo_master_fifo.sv | 59 +++++
 rtl/ahb_spi_fifo_master.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_spi_pkg.sv
// Shared definitions for the AHB-Lite SPI FIFO master: register offsets,
// CTRL/STATUS/IRQ_MASK bit positions and the shift-engine state encoding.
package ahb_spi_pkg;

    localparam logic [7:0] ADDR_CTRL     = 8'h00;
    localparam logic [7:0] ADDR_STATUS   = 8'h04;
    localparam logic [7:0] ADDR_SS       = 8'h08;
    localparam logic [7:0] ADDR_TXDATA   = 8'h0C;
    localparam logic [7:0] ADDR_RXDATA   = 8'h10;
    localparam logic [7:0] ADDR_IRQ_MASK = 8'h14;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_CPOL    = 1;
    localparam int CTRL_CPHA    = 2;
    localparam int CTRL_SS_AH   = 3;
    localparam int CTRL_DIV_LSB = 8;

    localparam int ST_BUSY       = 0;
    localparam int ST_TX_FULL    = 1;
    localparam int ST_TX_EMPTY   = 2;
    localparam int ST_RX_FULL    = 3;
    localparam int ST_RX_EMPTY   = 4;
    localparam int ST_RX_OVF     = 5;
    localparam int ST_TX_OVF     = 6;
    localparam int ST_TX_LVL_LSB = 8;
    localparam int ST_RX_LVL_LSB = 16;

    localparam int IRQ_TX_EMPTY     = 0;
    localparam int IRQ_RX_NOT_EMPTY = 1;
    localparam int IRQ_OVF          = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEAD  = 2'd1,
        S_TRAIL = 2'd2,
        S_GAP   = 2'd3
    } spi_state_e;

endpackage

// File: rtl/ahb_spi_fifo_master_fifo.sv
// Synchronous FIFO used for the TX and RX paths; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module spi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem_q[rptr_q];
    assign level   = count_q;

    always_comb begin
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        if (do_push && !do_pop)
            count_d = count_q + 1'b1;
        else if (do_pop && !do_push)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/ahb_spi_fifo_master.sv
// AHB-Lite SPI master with TX/RX FIFOs, clock divider and all CPOL/CPHA modes.
// Optional interrupt output and IRQ_MASK register enabled by AHB_SPI_IRQ_EN.
//   state   | meaning
//   S_IDLE  | no frame in flight, SCLK at CTRL.CPOL
//   S_LEAD  | half-period ending in the leading SCLK edge
//   S_TRAIL | half-period ending in the trailing SCLK edge
//   S_GAP   | one idle half-period after a frame, RX word already pushed
module ahb_spi_fifo_master
    import ahb_spi_pkg::*;
#(
    parameter int NUM_SS     = 4,
    parameter int FRAME_BITS = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 8
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic              HREADY,
    input  logic [31:0]       HADDR,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [1:0]        HTRANS,
    input  logic [31:0]       HWDATA,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    input  logic              SPI_MISO_i,
    output logic              SPI_MOSI_o,
    output logic              SPI_CLK_o,
    output logic [NUM_SS-1:0] SPI_SS_o
`ifdef AHB_SPI_IRQ_EN
    ,output logic             IRQ_o
`endif
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int BC_W  = $clog2(FRAME_BITS);

    logic [7:0]            addr_q, addr_d;
    logic                  wr_q, wr_d, rd_q, rd_d;
    logic                  en_q, en_d, cpol_q, cpol_d, cpha_q, cpha_d, ss_ah_q, ss_ah_d;
    logic [DIV_W-1:0]      clkdiv_q, clkdiv_d;
    logic [NUM_SS-1:0]     ss_q, ss_d;
    logic                  rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
    spi_state_e            state_q, state_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d, l_div_q, l_div_d;
    logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d, rx_sh_q, rx_sh_d;
    logic                  mosi_q, mosi_d, l_cpol_q, l_cpol_d, l_cpha_q, l_cpha_d;
    logic                  tx_push, tx_pop, rx_push, rx_pop, load;
    logic                  tx_full, tx_empty, rx_full, rx_empty;
    logic [FRAME_BITS-1:0] tx_rdata, rx_rdata;
    logic [LVL_W-1:0]      tx_level, rx_level;
    logic                  unused_bits;

    assign unused_bits = ^{HSIZE, HADDR[31:8], HTRANS[0], HWDATA};
    assign HREADYOUT   = 1'b1;
    assign tx_push     = wr_q && (addr_q == ADDR_TXDATA);
    assign rx_pop      = rd_q && (addr_q == ADDR_RXDATA);
    assign SPI_MOSI_o  = mosi_q;
    assign SPI_SS_o    = ss_ah_q ? ss_q : ~ss_q;
    assign SPI_CLK_o   = (state_q == S_TRAIL) ? ~l_cpol_q :
                         (state_q == S_IDLE)  ? cpol_q : l_cpol_q;

    spi_sync_fifo #(.WIDTH(FRAME_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(HCLK), .rst(HRESET), .push(tx_push), .pop(tx_pop),
        .wdata(HWDATA[FRAME_BITS-1:0]), .rdata(tx_rdata),
        .full(tx_full), .empty(tx_empty), .level(tx_level)
    );

    spi_sync_fifo #(.WIDTH(FRAME_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(HCLK), .rst(HRESET), .push(rx_push), .pop(rx_pop),
        .wdata(rx_sh_d), .rdata(rx_rdata),
        .full(rx_full), .empty(rx_empty), .level(rx_level)
    );

`ifdef AHB_SPI_IRQ_EN
    logic [2:0] irq_mask_q, irq_mask_d;
    logic       irq_q, irq_d;

    assign IRQ_o = irq_q;

    always_comb begin
        irq_mask_d = irq_mask_q;
        if (wr_q && addr_q == ADDR_IRQ_MASK)
            irq_mask_d = HWDATA[2:0];
        irq_d = (irq_mask_q[IRQ_TX_EMPTY] & tx_empty)
              | (irq_mask_q[IRQ_RX_NOT_EMPTY] & ~rx_empty)
              | (irq_mask_q[IRQ_OVF] & (rx_ovf_q | tx_ovf_q));
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            irq_mask_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_mask_q <= irq_mask_d;
            irq_q      <= irq_d;
        end
    end
`endif

    always_comb begin
        addr_d   = addr_q;
        wr_d     = 1'b0;
        rd_d     = 1'b0;
        en_d     = en_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        ss_ah_d  = ss_ah_q;
        clkdiv_d = clkdiv_q;
        ss_d     = ss_q;
        rx_ovf_d = rx_ovf_q;
        tx_ovf_d = tx_ovf_q;
        if (HREADY) begin
            addr_d = HADDR[7:0];
            wr_d   = HSEL & HTRANS[1] & HWRITE;
            rd_d   = HSEL & HTRANS[1] & ~HWRITE;
        end
        if (wr_q && addr_q == ADDR_CTRL) begin
            en_d     = HWDATA[CTRL_EN];
            cpol_d   = HWDATA[CTRL_CPOL];
            cpha_d   = HWDATA[CTRL_CPHA];
            ss_ah_d  = HWDATA[CTRL_SS_AH];
            clkdiv_d = HWDATA[CTRL_DIV_LSB +: DIV_W];
        end
        if (wr_q && addr_q == ADDR_SS)
            ss_d = HWDATA[NUM_SS-1:0];
        if (wr_q && addr_q == ADDR_STATUS) begin
            if (HWDATA[ST_RX_OVF]) rx_ovf_d = 1'b0;
            if (HWDATA[ST_TX_OVF]) tx_ovf_d = 1'b0;
        end
        // a same-cycle pop frees a slot, so only a truly dropped word flags overflow
        if (rx_push && rx_full && !rx_pop) rx_ovf_d = 1'b1;
        if (tx_push && tx_full && !tx_pop) tx_ovf_d = 1'b1;
    end

    always_comb begin
        HRDATA = '0;
        if (rd_q) begin
            case (addr_q)
                ADDR_CTRL: begin
                    HRDATA[CTRL_EN]              = en_q;
                    HRDATA[CTRL_CPOL]            = cpol_q;
                    HRDATA[CTRL_CPHA]            = cpha_q;
                    HRDATA[CTRL_SS_AH]           = ss_ah_q;
                    HRDATA[CTRL_DIV_LSB +: DIV_W] = clkdiv_q;
                end
                ADDR_STATUS: begin
                    HRDATA[ST_BUSY]                = (state_q != S_IDLE);
                    HRDATA[ST_TX_FULL]             = tx_full;
                    HRDATA[ST_TX_EMPTY]            = tx_empty;
                    HRDATA[ST_RX_FULL]             = rx_full;
                    HRDATA[ST_RX_EMPTY]            = rx_empty;
                    HRDATA[ST_RX_OVF]              = rx_ovf_q;
                    HRDATA[ST_TX_OVF]              = tx_ovf_q;
                    HRDATA[ST_TX_LVL_LSB +: LVL_W] = tx_level;
                    HRDATA[ST_RX_LVL_LSB +: LVL_W] = rx_level;
                end
                ADDR_SS:     HRDATA[NUM_SS-1:0] = ss_q;
                ADDR_RXDATA: if (!rx_empty) HRDATA[FRAME_BITS-1:0] = rx_rdata;
`ifdef AHB_SPI_IRQ_EN
                ADDR_IRQ_MASK: HRDATA[2:0] = irq_mask_q;
`endif
                default: HRDATA = '0;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rx_sh_d   = rx_sh_q;
        mosi_d    = mosi_q;
        l_cpol_d  = l_cpol_q;
        l_cpha_d  = l_cpha_q;
        l_div_d   = l_div_q;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        load      = 1'b0;
        case (state_q)
            S_IDLE: load = en_q & ~tx_empty;
            S_LEAD: begin
                if (div_cnt_q == '0) begin
                    state_d   = S_TRAIL;
                    div_cnt_d = l_div_q;
                    if (!l_cpha_q) begin
                        rx_sh_d = {rx_sh_q[FRAME_BITS-2:0], SPI_MISO_i};
                    end else begin
                        mosi_d  = shift_q[FRAME_BITS-1];
                        shift_d = shift_q << 1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q - 1'b1;
                end
            end
            S_TRAIL: begin
                if (div_cnt_q == '0) begin
                    div_cnt_d = l_div_q;
                    if (!l_cpha_q) begin
                        mosi_d  = shift_q[FRAME_BITS-1];
                        shift_d = shift_q << 1;
                    end else begin
                        rx_sh_d = {rx_sh_q[FRAME_BITS-2:0], SPI_MISO_i};
                    end
                    if (bit_cnt_q == '0) begin
                        state_d = S_GAP;
                        rx_push = 1'b1;
                    end else begin
                        state_d   = S_LEAD;
                        bit_cnt_d = bit_cnt_q - 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q - 1'b1;
                end
            end
            S_GAP: begin
                if (div_cnt_q == '0) begin
                    load = en_q & ~tx_empty;
                    if (!load) state_d = S_IDLE;
                end else begin
                    div_cnt_d = div_cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load) begin
            tx_pop    = 1'b1;
            state_d   = S_LEAD;
            l_cpol_d  = cpol_q;
            l_cpha_d  = cpha_q;
            l_div_d   = clkdiv_q;
            div_cnt_d = clkdiv_q;
            bit_cnt_d = BC_W'(FRAME_BITS - 1);
            // CPHA=0 presents the MSB for the whole first half-period
            if (!cpha_q) begin
                mosi_d  = tx_rdata[FRAME_BITS-1];
                shift_d = tx_rdata << 1;
            end else begin
                shift_d = tx_rdata;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_q    <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            en_q      <= 1'b0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            ss_ah_q   <= 1'b0;
            clkdiv_q  <= '0;
            ss_q      <= '0;
            rx_ovf_q  <= 1'b0;
            tx_ovf_q  <= 1'b0;
            state_q   <= S_IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            rx_sh_q   <= '0;
            mosi_q    <= 1'b0;
            l_cpol_q  <= 1'b0;
            l_cpha_q  <= 1'b0;
            l_div_q   <= '0;
        end else begin
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            en_q      <= en_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            ss_ah_q   <= ss_ah_d;
            clkdiv_q  <= clkdiv_d;
            ss_q      <= ss_d;
            rx_ovf_q  <= rx_ovf_d;
            tx_ovf_q  <= tx_ovf_d;
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rx_sh_q   <= rx_sh_d;
            mosi_q    <= mosi_d;
            l_cpol_q  <= l_cpol_d;
            l_cpha_q  <= l_cpha_d;
            l_div_q   <= l_div_d;
        end
    end

endmodule
